// File: rtl/sched_pkg.sv
// Shared types and config address map helpers for the phase sequencer.
package sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Pulse channel registers start the config address map.
  localparam int unsigned PULSE_BASE = 0;

  // Window lo/hi pairs follow the pulse registers.
  function automatic int unsigned win_base(input int unsigned num_pulse);
    return PULSE_BASE + num_pulse;
  endfunction

  // Period register sits right after the last window pair.
  function automatic int unsigned limit_addr(input int unsigned num_pulse,
                                             input int unsigned num_win);
    return win_base(num_pulse) + 2 * num_win;
  endfunction

endpackage

// File: rtl/sched_cfg_regs.sv
// Shadow/active configuration banks. Writes only touch the shadow bank;
// commit copies shadow (including a same-cycle write) into the active bank.
module sched_cfg_regs
  import sched_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX       = 229,
  parameter int unsigned NUM_PULSE = 4,
  parameter int unsigned NUM_WIN   = 2,
  parameter int unsigned AW        = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                cfg_we,
  input  logic [AW-1:0]                       cfg_addr,
  input  logic [CNT_W-1:0]                    cfg_data,
  input  logic                                commit,
  output logic [NUM_PULSE-1:0][CNT_W-1:0]     pulse_at,
  output logic [NUM_WIN-1:0][CNT_W-1:0]       win_lo,
  output logic [NUM_WIN-1:0][CNT_W-1:0]       win_hi,
  output logic [CNT_W-1:0]                    limit
);

  localparam int unsigned WIN_BASE   = win_base(NUM_PULSE);
  localparam int unsigned LIMIT_ADDR = limit_addr(NUM_PULSE, NUM_WIN);

  logic [NUM_PULSE-1:0][CNT_W-1:0] sh_pulse,  sh_pulse_nxt;
  logic [NUM_WIN-1:0][CNT_W-1:0]   sh_lo,     sh_lo_nxt;
  logic [NUM_WIN-1:0][CNT_W-1:0]   sh_hi,     sh_hi_nxt;
  logic [CNT_W-1:0]                sh_limit,  sh_limit_nxt;

  // Shadow bank with the current write applied; committing this value
  // is what forwards a write landing in the commit cycle.
  always_comb begin
    sh_pulse_nxt = sh_pulse;
    sh_lo_nxt    = sh_lo;
    sh_hi_nxt    = sh_hi;
    sh_limit_nxt = sh_limit;
    if (cfg_we) begin
      for (int unsigned i = 0; i < NUM_PULSE; i++) begin
        if (cfg_addr == AW'(PULSE_BASE + i)) sh_pulse_nxt[i] = cfg_data;
      end
      for (int unsigned j = 0; j < NUM_WIN; j++) begin
        if (cfg_addr == AW'(WIN_BASE + 2 * j))     sh_lo_nxt[j] = cfg_data;
        if (cfg_addr == AW'(WIN_BASE + 2 * j + 1)) sh_hi_nxt[j] = cfg_data;
      end
      if (cfg_addr == AW'(LIMIT_ADDR)) begin
        sh_limit_nxt = (cfg_data < CNT_W'(2)) ? CNT_W'(2) : cfg_data;
      end
    end
  end

  // Shadow always tracks writes; active bank updates only on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_pulse <= '1;
      sh_lo    <= '0;
      sh_hi    <= '0;
      sh_limit <= CNT_W'(MAX);
      pulse_at <= '1;
      win_lo   <= '0;
      win_hi   <= '0;
      limit    <= CNT_W'(MAX);
    end else begin
      sh_pulse <= sh_pulse_nxt;
      sh_lo    <= sh_lo_nxt;
      sh_hi    <= sh_hi_nxt;
      sh_limit <= sh_limit_nxt;
      if (commit) begin
        pulse_at <= sh_pulse_nxt;
        win_lo   <= sh_lo_nxt;
        win_hi   <= sh_hi_nxt;
        limit    <= sh_limit_nxt;
      end
    end
  end

endmodule

// File: rtl/sched_seq.sv
// Programmable phase sequencer: period counter, one-cycle event pulses and
// mode windows, with one-shot runs and boundary-committed reconfiguration.
module sched_seq
  import sched_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX       = 229,
  parameter int unsigned NUM_PULSE = 4,
  parameter int unsigned NUM_WIN   = 2,
  parameter int unsigned AW        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sync_clr,
  input  logic                 en,
  input  logic                 start,
  input  logic                 oneshot,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [CNT_W-1:0]     cfg_data,
  output logic [CNT_W-1:0]     count,
  output logic                 busy,
  output logic                 wrap,
  output logic [NUM_PULSE-1:0] pulse,
  output logic [NUM_WIN-1:0]   win
);

  state_t                          state, state_nxt;
  logic                            os_q, os_nxt;
  logic [CNT_W-1:0]                count_nxt;
  logic                            wrap_nxt;
  logic [NUM_PULSE-1:0]            pulse_nxt;
  logic                            wrap_evt;
  logic                            commit;
  logic [CNT_W-1:0]                limit_m1;
  logic [NUM_PULSE-1:0][CNT_W-1:0] pulse_at;
  logic [NUM_WIN-1:0][CNT_W-1:0]   win_lo;
  logic [NUM_WIN-1:0][CNT_W-1:0]   win_hi;
  logic [CNT_W-1:0]                limit;

  assign limit_m1 = limit - CNT_W'(1);
  assign wrap_evt = (state == RUN) && en && (count == limit_m1);
  // Count is 0 whenever a commit happens, so a shrinking limit never overshoots.
  assign commit   = (state == IDLE) || wrap_evt || sync_clr;

  sched_cfg_regs #(
    .CNT_W     (CNT_W),
    .MAX       (MAX),
    .NUM_PULSE (NUM_PULSE),
    .NUM_WIN   (NUM_WIN),
    .AW        (AW)
  ) u_cfg (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .commit   (commit),
    .pulse_at (pulse_at),
    .win_lo   (win_lo),
    .win_hi   (win_hi),
    .limit    (limit)
  );

  // Next-state, counter and pulse decode; sync_clr overrides everything.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    os_nxt    = os_q;
    wrap_nxt  = 1'b0;
    pulse_nxt = '0;
    if (sync_clr) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start || (!oneshot && en)) begin
            state_nxt = RUN;
            os_nxt    = oneshot;
          end
        end
        RUN: begin
          if (en) begin
            for (int unsigned i = 0; i < NUM_PULSE; i++) begin
              pulse_nxt[i] = (count == pulse_at[i]);
            end
            if (count == limit_m1) begin
              count_nxt = '0;
              wrap_nxt  = 1'b1;
              if (os_q) state_nxt = IDLE;
            end else begin
              count_nxt = count + CNT_W'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, counter and registered output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      os_q  <= 1'b0;
      wrap  <= 1'b0;
      pulse <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      os_q  <= os_nxt;
      wrap  <= wrap_nxt;
      pulse <= pulse_nxt;
      busy  <= (state_nxt == RUN);
    end
  end

  // Window decodes straight from the count register, no latency.
  always_comb begin
    win = '0;
    for (int unsigned j = 0; j < NUM_WIN; j++) begin
      win[j] = (state == RUN) && (count >= win_lo[j]) && (count < win_hi[j]);
    end
  end

endmodule

// File: tb/tb_sched_seq.sv
// Directed bench for sched_seq with hand-derived expected values.
module tb_sched_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sync_clr = 1'b0;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic       oneshot = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic [7:0] count;
  logic       busy;
  logic       wrap;
  logic [3:0] pulse;
  logic [1:0] win;

  int checks = 0;
  int passes = 0;

  logic [7:0] exp_c;
  logic [7:0] cur_lim;
  logic [7:0] pend_lim;
  logic       exp_w;
  logic [3:0] exp_p;
  logic [1:0] exp_win;

  sched_seq #(
    .CNT_W     (8),
    .MAX       (229),
    .NUM_PULSE (4),
    .NUM_WIN   (2),
    .AW        (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync_clr (sync_clr),
    .en       (en),
    .start    (start),
    .oneshot  (oneshot),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .count    (count),
    .busy     (busy),
    .wrap     (wrap),
    .pulse    (pulse),
    .win      (win)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 0; start = 0; oneshot = 0; sync_clr = 0; cfg_we = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    cfg_we = 1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic test_reset();
    en = 0; start = 0; oneshot = 0; sync_clr = 0; cfg_we = 0;
    rst_n = 0;
    tick();
    checks++; if (count !== 8'd0) $display("FAIL reset_count: got %0d want 0", count); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (wrap !== 1'b0) $display("FAIL reset_wrap: got %b want 0", wrap); else passes++;
    checks++; if (pulse !== 4'd0) $display("FAIL reset_pulse: got %b want 0000", pulse); else passes++;
    checks++; if (win !== 2'd0) $display("FAIL reset_win: got %b want 00", win); else passes++;
    rst_n = 1;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passes++;
  endtask

  task automatic test_free_run();
    do_reset();
    en = 1;
    tick();
    checks++; if (count !== 8'd0 || busy !== 1'b1) $display("FAIL free_entry: count %0d busy %b want 0 1", count, busy); else passes++;
    exp_c = 0;
    for (int k = 0; k < 2 * 229 + 3; k++) begin
      tick();
      exp_w = (exp_c == 8'd228);
      exp_c = exp_w ? 8'd0 : exp_c + 8'd1;
      checks++; if (count !== exp_c) $display("FAIL free_count: got %0d want %0d", count, exp_c); else passes++;
      checks++; if (wrap !== exp_w) $display("FAIL free_wrap at %0d: got %b want %b", exp_c, wrap, exp_w); else passes++;
      checks++; if (pulse !== 4'd0 || win !== 2'd0) $display("FAIL free_quiet: pulse %b win %b want 0", pulse, win); else passes++;
    end
  endtask

  task automatic test_schedule();
    do_reset();
    cfg_write(4'd0, 8'd28);
    cfg_write(4'd1, 8'd98);
    cfg_write(4'd2, 8'd214);
    cfg_write(4'd4, 8'd89);
    cfg_write(4'd5, 8'd98);
    en = 1;
    tick();
    exp_c = 0;
    for (int k = 0; k < 235; k++) begin
      tick();
      exp_c = (exp_c == 8'd228) ? 8'd0 : exp_c + 8'd1;
      exp_p = {1'b0, exp_c == 8'd215, exp_c == 8'd99, exp_c == 8'd29};
      exp_win = {1'b0, (exp_c >= 8'd89) && (exp_c <= 8'd97)};
      checks++; if (count !== exp_c) $display("FAIL sched_count: got %0d want %0d", count, exp_c); else passes++;
      checks++; if (pulse !== exp_p) $display("FAIL sched_pulse at %0d: got %b want %b", exp_c, pulse, exp_p); else passes++;
      checks++; if (win !== exp_win) $display("FAIL sched_win at %0d: got %b want %b", exp_c, win, exp_win); else passes++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    cfg_write(4'd0, 8'd28);
    cfg_write(4'd4, 8'd89);
    cfg_write(4'd5, 8'd98);
    en = 1;
    tick();
    for (int k = 0; k < 28; k++) tick();
    checks++; if (count !== 8'd28) $display("FAIL stall_reach: got %0d want 28", count); else passes++;
    en = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (count !== 8'd28 || pulse !== 4'd0 || win !== 2'd0) $display("FAIL stall28_hold: count %0d pulse %b win %b want 28 0000 00", count, pulse, win); else passes++;
    end
    en = 1;
    tick();
    checks++; if (count !== 8'd29 || pulse !== 4'b0001) $display("FAIL stall28_fire: count %0d pulse %b want 29 0001", count, pulse); else passes++;
    tick();
    checks++; if (count !== 8'd30 || pulse !== 4'd0) $display("FAIL stall28_once: count %0d pulse %b want 30 0000", count, pulse); else passes++;
    for (int k = 0; k < 60; k++) tick();
    checks++; if (count !== 8'd90 || win !== 2'b01) $display("FAIL stall90_reach: count %0d win %b want 90 01", count, win); else passes++;
    en = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (count !== 8'd90 || win !== 2'b01 || pulse !== 4'd0) $display("FAIL stall90_hold: count %0d win %b pulse %b want 90 01 0000", count, win, pulse); else passes++;
    end
    en = 1;
    tick();
    checks++; if (count !== 8'd91 || win !== 2'b01) $display("FAIL stall90_resume: count %0d win %b want 91 01", count, win); else passes++;
  endtask

  task automatic test_double_buffer();
    do_reset();
    en = 1;
    tick();
    for (int k = 0; k < 50; k++) tick();
    checks++; if (count !== 8'd50) $display("FAIL dbuf_reach: got %0d want 50", count); else passes++;
    cfg_write(4'd8, 8'd10);
    exp_c = 51; cur_lim = 229; pend_lim = 10;
    checks++; if (count !== exp_c) $display("FAIL dbuf_write_cycle: got %0d want 51", count); else passes++;
    for (int k = 0; k < 240; k++) begin
      if (k == 200) begin
        cfg_we = 1; cfg_addr = 4'd8; cfg_data = 8'd1;
        pend_lim = 2;
      end
      tick();
      cfg_we = 0;
      exp_w = (exp_c == cur_lim - 8'd1);
      if (exp_w) begin
        exp_c = 0;
        cur_lim = pend_lim;
      end else begin
        exp_c = exp_c + 8'd1;
      end
      checks++; if (count !== exp_c) $display("FAIL dbuf_count: got %0d want %0d (limit %0d)", count, exp_c, cur_lim); else passes++;
      checks++; if (wrap !== exp_w) $display("FAIL dbuf_wrap: got %b want %b at count %0d", wrap, exp_w, exp_c); else passes++;
    end
  endtask

  task automatic test_oneshot();
    int busy_n;
    int wraps;
    do_reset();
    cfg_write(4'd8, 8'd10);
    oneshot = 1; start = 1; en = 1;
    tick();
    start = 0;
    checks++; if (busy !== 1'b1 || count !== 8'd0) $display("FAIL os_entry: busy %b count %0d want 1 0", busy, count); else passes++;
    busy_n = 1; wraps = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (busy) busy_n++;
      if (wrap) wraps++;
    end
    checks++; if (busy_n !== 10) $display("FAIL os_busy_cycles: got %0d want 10", busy_n); else passes++;
    checks++; if (wraps !== 1) $display("FAIL os_wraps: got %0d want 1", wraps); else passes++;
    checks++; if (busy !== 1'b0 || count !== 8'd0) $display("FAIL os_idle: busy %b count %0d want 0 0", busy, count); else passes++;

    start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 5; k++) tick();
    checks++; if (count !== 8'd5 || busy !== 1'b1) $display("FAIL clr_reach: count %0d busy %b want 5 1", count, busy); else passes++;
    sync_clr = 1; start = 1;
    tick();
    sync_clr = 0; start = 0;
    checks++; if (count !== 8'd0 || busy !== 1'b0 || wrap !== 1'b0 || pulse !== 4'd0) $display("FAIL clr_now: count %0d busy %b wrap %b pulse %b want 0 0 0 0000", count, busy, wrap, pulse); else passes++;
    tick();
    tick();
    checks++; if (count !== 8'd0 || busy !== 1'b0) $display("FAIL clr_not_armed: count %0d busy %b want 0 0", count, busy); else passes++;
  endtask

  task automatic test_async_reset();
    do_reset();
    cfg_write(4'd8, 8'd150);
    en = 1;
    tick();
    for (int k = 0; k < 100; k++) tick();
    checks++; if (count !== 8'd100 || busy !== 1'b1) $display("FAIL ares_reach: count %0d busy %b want 100 1", count, busy); else passes++;
    #2;
    rst_n = 0;
    #1;
    checks++; if (count !== 8'd0 || busy !== 1'b0 || wrap !== 1'b0 || pulse !== 4'd0) $display("FAIL ares_immediate: count %0d busy %b wrap %b pulse %b want 0 0 0 0000", count, busy, wrap, pulse); else passes++;
    tick();
    rst_n = 1;
    tick();
    checks++; if (count !== 8'd0 || busy !== 1'b1) $display("FAIL ares_restart: count %0d busy %b want 0 1", count, busy); else passes++;
    exp_c = 0;
    for (int k = 0; k < 235; k++) begin
      tick();
      exp_w = (exp_c == 8'd228);
      exp_c = exp_w ? 8'd0 : exp_c + 8'd1;
      checks++; if (count !== exp_c) $display("FAIL ares_limit_count: got %0d want %0d", count, exp_c); else passes++;
      checks++; if (wrap !== exp_w) $display("FAIL ares_limit_wrap: got %b want %b at count %0d", wrap, exp_w, exp_c); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_schedule();
    test_stall();
    test_double_buffer();
    test_oneshot();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sched_seq.md
Name: sched_seq

Overview:
- Parametrised phase sequencer for the pipelined inverse/mat_mult datapaths.
- Generalises the fixed per-datapath phase counter and hard-coded compare decodes into one block:
  - free-running counter with a programmable period;
  - NUM_PULSE programmable one-cycle event pulses, for example sub-block resets;
  - NUM_WIN programmable mode windows, for example mat_mode.
- Adds one-shot runs and double-buffered runtime reconfiguration that commits only at period boundaries.

Parameters:
- CNT_W, 8: counter and compare-value width.
- MAX, 229: reset value of the period (limit) register.
- NUM_PULSE, 4: number of pulse channels.
- NUM_WIN, 2: number of window channels.
- AW, 4: config address width. Must satisfy 2^AW ≥ NUM_PULSE + 2·NUM_WIN + 1.

Ports:
- clk  in  1: single clock, all state on posedge.
- rst_n  in  1: asynchronous, active-low reset.
- sync_clr  in  1: synchronous restart.
- en  in  1: advance enable.
- start  in  1: arms a run from IDLE.
- oneshot  in  1: run mode, sampled when a run starts.
- cfg_we  in  1: config write strobe.
- cfg_addr  in  AW: config register select.
- cfg_data  in  CNT_W: config write data.
- count  out  CNT_W: current phase.
- busy  out  1: high in RUN.
- wrap  out  1: one-cycle pulse at period end.
- pulse  out  NUM_PULSE: registered event pulses.
- win  out  NUM_WIN: window decodes.

Behaviour:
- Reset (rst_n=0, async) sets:
  - state=IDLE; count, wrap, pulse, busy = 0.
  - limit=MAX; pulse_at[i]=all-ones, which never matches; win_lo[j]=win_hi[j]=0, so windows are empty.
  - Shadow registers equal active registers.
- Config map:
  - addr i < NUM_PULSE → pulse_at[i].
  - NUM_PULSE+2j → win_lo[j]; NUM_PULSE+2j+1 → win_hi[j].
  - NUM_PULSE+2·NUM_WIN → limit.
  - Other addresses are ignored.
- Limit writes below 2 are stored as 2.
- Writes land in the shadow bank only.
- Shadow is copied to the active bank (commit) when:
  - state is IDLE; or
  - on the wrap edge; or
  - on sync_clr.
- A write in the commit cycle is forwarded, so the new value is active from the next cycle.
- State machine, IDLE → RUN when:
  - start=1; or
  - oneshot=0 and en=1.
  - On entry, oneshot is latched into os_q and count stays 0.
- In RUN with en=1:
  - If count == limit-1: count←0, wrap←1 for one cycle, commit. Then go to IDLE if os_q, else stay in RUN.
  - Otherwise count←count+1.
- In RUN with en=0: count holds and no new pulses are generated.
- Pulses: pulse[i] is registered. It is set the cycle after a cycle with state=RUN, en=1 and count==active pulse_at[i], and is high for exactly one cycle.
  - A stalled en never stretches a pulse.
  - pulse_at ≥ limit never fires.
- Windows: win[j] = RUN && (win_lo[j] ≤ count < win_hi[j]), combinational from the count register, zero latency. If lo ≥ hi the window is never asserted.
- busy = (state==RUN), registered.
- sync_clr has priority over everything except rst_n. It sets count←0, state←IDLE, clears wrap and pulse next cycle, and commits shadow.
- If sync_clr and start arrive together, sync_clr wins; start is dropped.
- Count never exceeds limit-1.
- If limit shrinks at commit, count is already 0, so there is no overshoot.
- rst_n asserted mid-run aborts immediately, with the reset values above.

Decomposition:
- sched_pkg holds:
  - state enum {IDLE, RUN};
  - config address constants PULSE_BASE, WIN_BASE, LIMIT_ADDR, derived from the parameters;
  - a function computing LIMIT_ADDR.
- One sub-module, sched_cfg_regs: shadow/active register banks, clamp, commit with write forwarding.
- Counter, FSM and output decode stay in sched_seq.

Test Plan:
- Defaults, oneshot=0, en=1 held: count runs 0..228, wraps to 0, and wrap pulses once every 229 cycles. Pulse and win outputs stay 0 throughout.
- Reset-schedule equivalence:
  - Config: pulse_at0=28, pulse_at1=98, pulse_at2=214; window0 lo=89, hi=98.
  - Response: pulse bits high one cycle after count 28, 98 and 214; win0 high exactly for count 89..97.
- Stall: drop en for 5 cycles at count=28 → pulse0 high for exactly 1 cycle, count holds at 28, and win0 is unaffected.
- Double buffering:
  - In RUN at count=50, write limit=10 → period stays 229 until the next wrap, then count cycles 0..9.
  - Writing limit=1 stores 2, giving count pattern 0,1,0,1.
- One-shot with a mid-run clear:
  - oneshot=1, start pulse, limit=10 → busy for 10 en-cycles, one wrap, then IDLE with count=0.
  - sync_clr asserted together with start at count=5 → next cycle count=0, busy=0, and no run is armed.
- Async reset mid-run at count=100: count, busy, pulse and wrap go to 0 without waiting for a clock edge, and limit returns to 229.
